// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the memory port arbiter: bus widths, the
// wait-counter width and the response FSM state encoding.
package mem_port_arbiter_pkg;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 16;
    localparam int WAIT_W = 4;

    typedef enum logic [1:0] {
        RSP_NONE = 2'd0,
        RSP_UP   = 2'd1,
        RSP_HOST = 2'd2
    } rsp_state_e;

endpackage

// File: rtl/mem_port_arbiter_prio.sv
// Two-way priority arbiter with starvation guard for the SRAM port.
// start=1 gives the processor priority, start=0 gives the host priority.
// The low-priority side counts its denied cycles and is forced through
// once the count reaches MAX_WAIT. A change of start restarts the count,
// because the denials so far were counted against the other requester.
module arb_prio_2way
    import mem_port_arbiter_pkg::*;
#(
    parameter int MAX_WAIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic up_req,
    input  logic host_req,
    output logic up_gnt,
    output logic host_gnt
);

    localparam logic [WAIT_W-1:0] MAX_WAIT_V = WAIT_W'(MAX_WAIT);

    logic [WAIT_W-1:0] wait_cnt;
    logic [WAIT_W-1:0] wait_eff;
    logic [WAIT_W-1:0] wait_nxt;
    logic              start_q;
    logic              start_edge;
    logic              low_req;
    logic              high_req;
    logic              low_gnt;
    logic              high_gnt;
    logic              force_low;

    // Resolve priority and grants from the live requests and the wait count
    always_comb begin
        start_edge = start ^ start_q;
        low_req    = start ? host_req : up_req;
        high_req   = start ? up_req   : host_req;
        wait_eff   = start_edge ? '0 : wait_cnt;
        force_low  = low_req && (wait_eff == MAX_WAIT_V);
        low_gnt    = !reset && low_req && (!high_req || force_low);
        high_gnt   = !reset && high_req && !low_gnt;
        up_gnt     = start ? high_gnt : low_gnt;
        host_gnt   = start ? low_gnt  : high_gnt;
        wait_nxt   = '0;
        if (!start_edge && low_req && !low_gnt) begin
            wait_nxt = (wait_eff == MAX_WAIT_V) ? wait_eff : wait_eff + 1'b1;
        end
    end

    // Register the denial count and the previous mode for edge detection
    always_ff @(posedge clk) begin
        start_q <= start;
        if (reset) begin
            wait_cnt <= '0;
        end else begin
            wait_cnt <= wait_nxt;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one synchronous SRAM between the processor and the host.
// Grants come from arb_prio_2way; this file holds the address/data mux,
// the held SRAM address/data and the read-response FSM.
// Optional macro MEM_PORT_ARBITER_PERF_EN adds per-port grant counters.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              up_req,
    input  logic              up_we,
    input  logic [ADDR_W-1:0] up_addr,
    input  logic [DATA_W-1:0] up_wdata,
    output logic              up_gnt,
    output logic              up_rvalid,
    output logic [DATA_W-1:0] up_rdata,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_gnt,
    output logic              host_rvalid,
    output logic [DATA_W-1:0] host_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_wen,
    output logic [7:0]        mem_wen_8bit,
`ifdef MEM_PORT_ARBITER_PERF_EN
    output logic [15:0]       up_grant_cnt,
    output logic [15:0]       host_grant_cnt,
`endif
    input  logic [DATA_W-1:0] mem_rdata
);

    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    rsp_state_e        rsp_q;
    rsp_state_e        rsp_nxt;

    arb_prio_2way #(
        .MAX_WAIT (MAX_WAIT)
    ) u_arb (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .up_req   (up_req),
        .host_req (host_req),
        .up_gnt   (up_gnt),
        .host_gnt (host_gnt)
    );

    // Drive the SRAM from the granted port, otherwise hold the last access
    always_comb begin
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        mem_wen   = 1'b1;
        if (up_gnt) begin
            mem_addr  = up_addr;
            mem_wdata = up_wdata;
            mem_wen   = ~up_we;
        end else if (host_gnt) begin
            mem_addr  = host_addr;
            mem_wdata = host_wdata;
            mem_wen   = ~host_we;
        end
        mem_wen_8bit = {8{mem_wen}};
    end

    // Response FSM: next owner is whoever got a read this cycle; outputs decode the current owner
    always_comb begin
        rsp_nxt = RSP_NONE;
        if (up_gnt && !up_we) begin
            rsp_nxt = RSP_UP;
        end else if (host_gnt && !host_we) begin
            rsp_nxt = RSP_HOST;
        end
        up_rvalid   = 1'b0;
        up_rdata    = '0;
        host_rvalid = 1'b0;
        host_rdata  = '0;
        if (!reset) begin
            case (rsp_q)
                RSP_UP: begin
                    up_rvalid = 1'b1;
                    up_rdata  = mem_rdata;
                end
                RSP_HOST: begin
                    host_rvalid = 1'b1;
                    host_rdata  = mem_rdata;
                end
                default: begin
                end
            endcase
        end
    end

    // Hold the last SRAM address/data and advance the response FSM
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q  <= '0;
            wdata_q <= '0;
            rsp_q   <= RSP_NONE;
        end else begin
            addr_q  <= mem_addr;
            wdata_q <= mem_wdata;
            rsp_q   <= rsp_nxt;
        end
    end

`ifdef MEM_PORT_ARBITER_PERF_EN
    // Count grants per port, wrapping naturally at 16 bits
    always_ff @(posedge clk) begin
        if (reset) begin
            up_grant_cnt   <= '0;
            host_grant_cnt <= '0;
        end else begin
            if (up_gnt) begin
                up_grant_cnt <= up_grant_cnt + 16'd1;
            end
            if (host_gnt) begin
                host_grant_cnt <= host_grant_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with MAX_WAIT=4 and a behavioural
// synchronous SRAM whose word at address a resets to {8'hA5, a}.
// Inputs change 1 time unit after each rising edge and outputs are
// sampled 1 time unit later, well away from the edge.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b1;
    logic        up_req = 1'b0;
    logic        up_we = 1'b0;
    logic [7:0]  up_addr = 8'h00;
    logic [15:0] up_wdata = 16'h0000;
    logic        up_gnt;
    logic        up_rvalid;
    logic [15:0] up_rdata;
    logic        host_req = 1'b0;
    logic        host_we = 1'b0;
    logic [7:0]  host_addr = 8'h00;
    logic [15:0] host_wdata = 16'h0000;
    logic        host_gnt;
    logic        host_rvalid;
    logic [15:0] host_rdata;
    logic [7:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_wen;
    logic [7:0]  mem_wen_8bit;
    logic [15:0] mem_rdata;
`ifdef MEM_PORT_ARBITER_PERF_EN
    logic [15:0] up_grant_cnt;
    logic [15:0] host_grant_cnt;
`endif

    logic [15:0] sram [256];
    int checks = 0;
    int failures = 0;

    mem_port_arbiter #(
        .MAX_WAIT (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .up_req       (up_req),
        .up_we        (up_we),
        .up_addr      (up_addr),
        .up_wdata     (up_wdata),
        .up_gnt       (up_gnt),
        .up_rvalid    (up_rvalid),
        .up_rdata     (up_rdata),
        .host_req     (host_req),
        .host_we      (host_we),
        .host_addr    (host_addr),
        .host_wdata   (host_wdata),
        .host_gnt     (host_gnt),
        .host_rvalid  (host_rvalid),
        .host_rdata   (host_rdata),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_wen      (mem_wen),
        .mem_wen_8bit (mem_wen_8bit),
`ifdef MEM_PORT_ARBITER_PERF_EN
        .up_grant_cnt   (up_grant_cnt),
        .host_grant_cnt (host_grant_cnt),
`endif
        .mem_rdata    (mem_rdata)
    );

    always #5 clk = ~clk;

    // Synchronous SRAM model, preloaded with a known pattern while reset is high
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 256; i++) sram[i] <= {8'hA5, 8'(i)};
        end else if (!mem_wen) begin
            sram[mem_addr] <= mem_wdata;
        end
        mem_rdata <= sram[mem_addr];
    end

    // Advance one cycle and apply a full input vector
    task automatic applyStimulus(input logic rst, input logic st,
                                 input logic ureq, input logic uwe, input logic [7:0] uaddr, input logic [15:0] uwd,
                                 input logic hreq, input logic hwe, input logic [7:0] haddr, input logic [15:0] hwd);
        @(posedge clk);
        #1;
        reset      = rst;
        start      = st;
        up_req     = ureq;
        up_we      = uwe;
        up_addr    = uaddr;
        up_wdata   = uwd;
        host_req   = hreq;
        host_we    = hwe;
        host_addr  = haddr;
        host_wdata = hwd;
        #1;
    endtask

    // Compare one observed value against its hand-computed expectation
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    initial begin
        // Reset: grants, write enable and rvalid suppressed even with a request present
        applyStimulus(1, 1, 1, 0, 8'h33, 16'h0, 0, 0, 8'h00, 16'h0);
        checkOutput("rst_up_gnt", 32'(up_gnt), 32'h0);
        checkOutput("rst_host_gnt", 32'(host_gnt), 32'h0);
        checkOutput("rst_mem_wen", 32'(mem_wen), 32'h1);
        checkOutput("rst_wen8", 32'(mem_wen_8bit), 32'hFF);
        applyStimulus(1, 1, 0, 0, 8'h00, 16'h0, 0, 0, 8'h00, 16'h0);
        checkOutput("rst_mem_addr", 32'(mem_addr), 32'h00);
        checkOutput("rst_mem_wdata", 32'(mem_wdata), 32'h0000);
        checkOutput("rst_up_rvalid", 32'(up_rvalid), 32'h0);
        checkOutput("rst_host_rvalid", 32'(host_rvalid), 32'h0);
        applyStimulus(0, 1, 0, 0, 8'h00, 16'h0, 0, 0, 8'h00, 16'h0);
        checkOutput("idle_mem_addr", 32'(mem_addr), 32'h00);
        checkOutput("idle_up_rdata", 32'(up_rdata), 32'h0000);

        // start=1 tie: uP first, host next cycle, rvalid one cycle after each grant
        applyStimulus(0, 1, 1, 0, 8'h10, 16'h0, 1, 0, 8'h20, 16'h0);
        checkOutput("tie1_up_gnt", 32'(up_gnt), 32'h1);
        checkOutput("tie1_host_gnt", 32'(host_gnt), 32'h0);
        checkOutput("tie1_mem_addr", 32'(mem_addr), 32'h10);
        applyStimulus(0, 1, 0, 0, 8'h00, 16'h0, 1, 0, 8'h20, 16'h0);
        checkOutput("tie1_host_gnt_c1", 32'(host_gnt), 32'h1);
        checkOutput("tie1_mem_addr_c1", 32'(mem_addr), 32'h20);
        checkOutput("tie1_up_rvalid", 32'(up_rvalid), 32'h1);
        checkOutput("tie1_up_rdata", 32'(up_rdata), 32'hA510);
        checkOutput("tie1_host_rdata_c1", 32'(host_rdata), 32'h0000);
        applyStimulus(0, 1, 0, 0, 8'h00, 16'h0, 0, 0, 8'h00, 16'h0);
        checkOutput("tie1_host_rvalid", 32'(host_rvalid), 32'h1);
        checkOutput("tie1_host_rdata", 32'(host_rdata), 32'hA520);
        checkOutput("tie1_up_rvalid_c2", 32'(up_rvalid), 32'h0);
        checkOutput("tie1_hold_addr", 32'(mem_addr), 32'h20);

        // Starvation guard: host denied four cycles, forced through on the fifth
        for (int i = 1; i <= 4; i++) begin
            applyStimulus(0, 1, 1, 0, 8'h01, 16'h0, 1, 0, 8'h02, 16'h0);
            checkOutput($sformatf("starve_up_gnt_%0d", i), 32'(up_gnt), 32'h1);
            checkOutput($sformatf("starve_host_gnt_%0d", i), 32'(host_gnt), 32'h0);
        end
        applyStimulus(0, 1, 1, 0, 8'h01, 16'h0, 1, 0, 8'h02, 16'h0);
        checkOutput("starve_host_gnt_5", 32'(host_gnt), 32'h1);
        checkOutput("starve_up_gnt_5", 32'(up_gnt), 32'h0);
        checkOutput("starve_addr_5", 32'(mem_addr), 32'h02);
        checkOutput("starve_up_rdata_5", 32'(up_rdata), 32'hA501);
        applyStimulus(0, 1, 1, 0, 8'h01, 16'h0, 0, 0, 8'h00, 16'h0);
        checkOutput("starve_up_resume", 32'(up_gnt), 32'h1);
        checkOutput("starve_host_rvalid", 32'(host_rvalid), 32'h1);
        checkOutput("starve_host_rdata", 32'(host_rdata), 32'hA502);
        checkOutput("starve_up_rvalid_6", 32'(up_rvalid), 32'h0);
        applyStimulus(0, 1, 0, 0, 8'h00, 16'h0, 0, 0, 8'h00, 16'h0);
        checkOutput("starve_up_rdata_7", 32'(up_rdata), 32'hA501);

        // start=0 tie: host first, then uP
        applyStimulus(0, 0, 1, 0, 8'h40, 16'h0, 1, 0, 8'h41, 16'h0);
        checkOutput("tie0_host_gnt", 32'(host_gnt), 32'h1);
        checkOutput("tie0_up_gnt", 32'(up_gnt), 32'h0);
        checkOutput("tie0_addr", 32'(mem_addr), 32'h41);
        applyStimulus(0, 0, 1, 0, 8'h40, 16'h0, 0, 0, 8'h00, 16'h0);
        checkOutput("tie0_up_gnt_c1", 32'(up_gnt), 32'h1);
        checkOutput("tie0_host_rdata", 32'(host_rdata), 32'hA541);
        applyStimulus(0, 0, 0, 0, 8'h00, 16'h0, 0, 0, 8'h00, 16'h0);
        checkOutput("tie0_up_rdata", 32'(up_rdata), 32'hA540);

        // Host write then readback
        applyStimulus(0, 0, 0, 0, 8'h00, 16'h0, 1, 1, 8'h05, 16'hBEEF);
        checkOutput("wr_host_gnt", 32'(host_gnt), 32'h1);
        checkOutput("wr_mem_wen", 32'(mem_wen), 32'h0);
        checkOutput("wr_wen8", 32'(mem_wen_8bit), 32'h00);
        checkOutput("wr_addr", 32'(mem_addr), 32'h05);
        checkOutput("wr_wdata", 32'(mem_wdata), 32'hBEEF);
        applyStimulus(0, 0, 0, 0, 8'h00, 16'h0, 1, 0, 8'h05, 16'h0);
        checkOutput("rd_host_gnt", 32'(host_gnt), 32'h1);
        checkOutput("rd_mem_wen", 32'(mem_wen), 32'h1);
        checkOutput("wr_no_rvalid", 32'(host_rvalid), 32'h0);
        applyStimulus(0, 0, 0, 0, 8'h00, 16'h0, 0, 0, 8'h00, 16'h0);
        checkOutput("rd_host_rvalid", 32'(host_rvalid), 32'h1);
        checkOutput("rd_host_rdata", 32'(host_rdata), 32'hBEEF);
        checkOutput("rd_idle_wen8", 32'(mem_wen_8bit), 32'hFF);

        // Reset right after a granted read drops the response
        applyStimulus(0, 0, 1, 0, 8'h10, 16'h0, 0, 0, 8'h00, 16'h0);
        checkOutput("rr_up_gnt", 32'(up_gnt), 32'h1);
        applyStimulus(1, 0, 1, 0, 8'h11, 16'h0, 1, 0, 8'h12, 16'h0);
        checkOutput("rr_up_rvalid", 32'(up_rvalid), 32'h0);
        checkOutput("rr_up_rdata", 32'(up_rdata), 32'h0000);
        checkOutput("rr_mem_wen", 32'(mem_wen), 32'h1);
        checkOutput("rr_up_gnt_rst", 32'(up_gnt), 32'h0);
        checkOutput("rr_host_gnt_rst", 32'(host_gnt), 32'h0);
        applyStimulus(0, 0, 0, 0, 8'h00, 16'h0, 0, 0, 8'h00, 16'h0);
        checkOutput("rr_up_rvalid_after", 32'(up_rvalid), 32'h0);
        checkOutput("rr_host_rvalid_after", 32'(host_rvalid), 32'h0);
        checkOutput("rr_mem_addr", 32'(mem_addr), 32'h00);

        // Host read granted while start rises; response still returns to host
        applyStimulus(0, 1, 0, 0, 8'h00, 16'h0, 1, 0, 8'h20, 16'h0);
        checkOutput("se_host_gnt", 32'(host_gnt), 32'h1);
        applyStimulus(0, 1, 1, 0, 8'h30, 16'h0, 0, 0, 8'h00, 16'h0);
        checkOutput("se_up_gnt", 32'(up_gnt), 32'h1);
        checkOutput("se_host_rvalid", 32'(host_rvalid), 32'h1);
        checkOutput("se_host_rdata", 32'(host_rdata), 32'hA520);
        checkOutput("se_up_rvalid", 32'(up_rvalid), 32'h0);
        applyStimulus(0, 1, 0, 0, 8'h00, 16'h0, 0, 0, 8'h00, 16'h0);
        checkOutput("se_up_rdata", 32'(up_rdata), 32'hA530);

        // Start edges clear the wait count: host builds up 3 denials, then start toggles
        for (int i = 1; i <= 3; i++) begin
            applyStimulus(0, 1, 1, 0, 8'h01, 16'h0, 1, 0, 8'h02, 16'h0);
            checkOutput($sformatf("clr_pre_up_gnt_%0d", i), 32'(up_gnt), 32'h1);
        end
        applyStimulus(0, 0, 1, 0, 8'h01, 16'h0, 1, 0, 8'h02, 16'h0);
        checkOutput("clr_fall_host_gnt", 32'(host_gnt), 32'h1);
        for (int i = 1; i <= 5; i++) begin
            applyStimulus(0, 1, 1, 0, 8'h01, 16'h0, 1, 0, 8'h02, 16'h0);
            checkOutput($sformatf("clr_post_up_gnt_%0d", i), 32'(up_gnt), 32'h1);
            checkOutput($sformatf("clr_post_host_gnt_%0d", i), 32'(host_gnt), 32'h0);
        end
        applyStimulus(0, 1, 1, 0, 8'h01, 16'h0, 1, 0, 8'h02, 16'h0);
        checkOutput("clr_forced_host_gnt", 32'(host_gnt), 32'h1);
        applyStimulus(0, 1, 0, 0, 8'h00, 16'h0, 0, 0, 8'h00, 16'h0);

`ifdef MEM_PORT_ARBITER_PERF_EN
        // Grant counters clear on reset and wrap after 65536 grants
        applyStimulus(1, 1, 0, 0, 8'h00, 16'h0, 0, 0, 8'h00, 16'h0);
        applyStimulus(0, 1, 0, 0, 8'h00, 16'h0, 0, 0, 8'h00, 16'h0);
        checkOutput("perf_up_rst", 32'(up_grant_cnt), 32'h0000);
        checkOutput("perf_host_rst", 32'(host_grant_cnt), 32'h0000);
        for (int i = 0; i < 65537; i++) begin
            applyStimulus(0, 1, 1, 0, 8'h00, 16'h0, 0, 0, 8'h00, 16'h0);
        end
        applyStimulus(0, 1, 0, 0, 8'h00, 16'h0, 0, 0, 8'h00, 16'h0);
        checkOutput("perf_up_wrap", 32'(up_grant_cnt), 32'h0001);
        checkOutput("perf_host_zero", 32'(host_grant_cnt), 32'h0000);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter: MAX_WAIT, default 4, meaning consecutive denied cycles after which the low-priority requester is forced to win (range 1..15).
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  mode; 1 = processor run (uP high priority), 0 = load mode (host high priority).
REQ-005 up_req / up_we  input  1 / 1  processor access request and write qualifier.
REQ-006 up_addr / up_wdata  input  8 / 16  processor data-memory address and write data.
REQ-007 up_gnt / up_rvalid  output  1 / 1  processor grant (same cycle) and read-data valid (next cycle).
REQ-008 up_rdata  output  16  processor read data.
REQ-009 host_req, host_we, host_addr[7:0], host_wdata[15:0], host_gnt, host_rvalid, host_rdata[15:0]: host port, same directions and meanings as the uP port.
REQ-010 mem_addr  output  8  SRAM address.
REQ-011 mem_wdata  output  16  SRAM write data.
REQ-012 mem_wen  output  1  SRAM write enable, active-low.
REQ-013 mem_wen_8bit  output  8  mem_wen replicated to 8 bits.
REQ-014 mem_rdata  input  16  SRAM read data, valid one cycle after address presented.

Function
REQ-015 At most one of up_gnt/host_gnt SHALL be 1 in any cycle; a grant is combinational from current requests and registered wait state.
REQ-016 Priority: start=1 -> uP wins ties; start=0 -> host wins ties; lone request always wins.
REQ-017 wait_cnt (4 bit) SHALL increment each cycle the low-priority requester requests and is denied, clear when it is granted or drops req; when wait_cnt==MAX_WAIT it SHALL win that cycle regardless of priority.
REQ-018 Granted port drives mem_addr/mem_wdata; mem_wen=0 only in a granted cycle with we=1; no grant -> mem_wen=1, mem_addr/mem_wdata hold last granted value.
REQ-019 Requester holds req/we/addr/wdata stable until gnt; one transfer per grant cycle; back-to-back grants allowed every cycle.
REQ-020 Response FSM states RSP_NONE, RSP_UP, RSP_HOST: next state = owner of a granted read this cycle, else RSP_NONE.
REQ-021 In RSP_UP: up_rvalid=1, up_rdata=mem_rdata; in RSP_HOST likewise for host; rdata of non-owner SHALL be 16'h0000.
REQ-022 Writes produce no rvalid; a read granted in cycle N yields rvalid exactly in cycle N+1 even if a new grant occurs in N+1.
REQ-023 start toggling changes priority the same cycle; wait_cnt SHALL clear on any start edge; pending response still completes to its original owner.
REQ-024 wait_cnt SHALL saturate at MAX_WAIT (no wrap).

Reset
REQ-025 reset=1 at a clock edge: FSM->RSP_NONE, wait_cnt=0, mem_addr=8'h00, mem_wdata=16'h0000; during reset both gnt=0, mem_wen=1, both rvalid=0.
REQ-026 Reset mid-read SHALL drop the pending response (no rvalid after reset).

Configuration
REQ-027 Macro MEM_PORT_ARBITER_PERF_EN defined: outputs up_grant_cnt[15:0] and host_grant_cnt[15:0], incremented per grant, wrapping 16'hFFFF->0, cleared by reset; undefined: ports and counters absent, function otherwise identical.

Structure
REQ-028 Shared package holds response-state encoding (RSP_NONE=2'd0, RSP_UP=2'd1, RSP_HOST=2'd2) and the 8/16-bit address/data width constants.
REQ-029 The grant logic plus wait_cnt SHALL be one sub-module, arb_prio_2way; datapath mux and response FSM stay in the top.

Verification
REQ-030 start=1, both req reads at addr 8'h10/8'h20 -> up_gnt cycle 0, mem_addr=8'h10, up_rvalid cycle 1 with SRAM data; host granted cycle 1.
REQ-031 start=1, uP requests every cycle, host holds req, MAX_WAIT=4 -> host_gnt exactly in 5th cycle of waiting, then uP resumes.
REQ-032 start=0, host write addr 8'h05 data 16'hBEEF -> mem_wen=0, mem_wen_8bit=8'h00 for one cycle, no rvalid; readback returns 16'hBEEF next cycle.
REQ-033 Read granted cycle N, reset asserted cycle N+1 -> no rvalid, mem_wen=1, all gnt=0.
REQ-034 Read granted to host, start rises same cycle -> host_rvalid next cycle; wait_cnt=0.
REQ-035 With MEM_PORT_ARBITER_PERF_EN, 65537 uP grants -> up_grant_cnt=16'h0001.
